fetch_decode_queue: RTL

- Prefetch byte queue between the memory fetch path and the opcode decoder.
- Buffers fetched bytes and predecodes each instruction's length (1/2/3 bytes) from the 6502 opcode layout.
- Presents whole assembled instructions (opcode plus operands plus PC) to decode through a valid/ready handshake.
- Successor to the single-opcode decode stage: adds depth parametrisation, multi-byte assembly, PC tracking and flush.

---
 rtl/fetch_decode_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_decode_queue.sv
// Prefetch byte queue: buffers fetched bytes, predecodes 6502 instruction length and hands
// whole instructions (opcode, operands, PC) to the decoder over a valid/ready handshake.
module fetch_decode_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned BRK_LEN  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [15:0]                  flush_pc,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_byte,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_opcode,
  output logic [7:0]                   out_op1,
  output logic [7:0]                   out_op2,
  output logic [1:0]                   out_len,
  output logic [15:0]                  out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fetch_decode_queue: DEPTH must be a power of 2 and at least 4");
  end
  if ((BRK_LEN != 1) && (BRK_LEN != 2)) begin : g_brk_len_check
    $error("fetch_decode_queue: BRK_LEN must be 1 or 2");
  end

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     pc_q, pc_d;
  logic [7:0]      head, byte1, byte2;
  logic [1:0]      len;
  logic            push, pop;

  // Operand bytes wrap naturally because DEPTH is a power of 2.
  assign head  = mem_q[rd_ptr_q];
  assign byte1 = mem_q[rd_ptr_q + PtrW'(1)];
  assign byte2 = mem_q[rd_ptr_q + PtrW'(2)];

  // Opcode layout aaa_bbb_cc: the bbb column and cc group decide length; first match wins.
  always_comb begin
    if (head == 8'h00) begin
      len = 2'(BRK_LEN);
    end else if ((head == 8'h40) || (head == 8'h60)) begin
      len = 2'd1;
    end else if (head == 8'h20) begin
      len = 2'd3;
    end else if ((head[3:2] == 2'b10) && !head[0]) begin
      len = 2'd1;
    end else if ((head[4:2] == 3'b011) || (head[4:2] == 3'b111)) begin
      len = 2'd3;
    end else if ((head[4:2] == 3'b110) && head[0]) begin
      len = 2'd3;
    end else begin
      len = 2'd2;
    end
  end

  assign out_valid  = (count_q >= CntW'(len)) && (count_q != '0);
  assign in_ready   = (count_q < CntW'(DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready && !flush;

  assign out_opcode = head;
  assign out_len    = len;
  assign out_op1    = (out_valid && (len != 2'd1)) ? byte1 : 8'h00;
  assign out_op2    = (out_valid && (len == 2'd3)) ? byte2 : 8'h00;
  assign out_pc     = pc_q;
  assign count      = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = flush_pc;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(len);
        pc_d     = pc_q + 16'(len);
      end
      count_d = count_q + CntW'(push) - (pop ? CntW'(len) : CntW'(0));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_byte;
    end
  end

endmodule
